// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared decimal-arithmetic definitions for the packed-BCD datapath blocks.
package bcd_serial_subtractor_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned RADIX = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract with borrow in/out and bad-digit flag.
module bcd_digit_sub
    import bcd_serial_subtractor_pkg::*;
(
    input  logic [BCD_W-1:0] a_d,
    input  logic [BCD_W-1:0] b_d,
    input  logic             bin,
    output logic [BCD_W-1:0] d,
    output logic             bout,
    output logic             bad
);

    // a_d - b_d - bin spans -16..15, so five bits hold it with t[4] as the sign.
    logic [BCD_W:0] t;

    always_comb begin
        t    = {1'b0, a_d} - {1'b0, b_d} - {{BCD_W{1'b0}}, bin};
        bout = t[BCD_W];
        d    = bout ? (t[BCD_W-1:0] + BCD_W'(RADIX)) : t[BCD_W-1:0];
        bad  = (a_d > BCD_W'(RADIX - 1)) | (b_d > BCD_W'(RADIX - 1));
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: A - B one digit per clock, LSD first, start/done handshake.
module bcd_serial_subtractor
    import bcd_serial_subtractor_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] diff,
    output logic                    borrow,
    output logic                    invalid
);

    localparam int unsigned W    = BCD_W * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_next;
    logic            bin_q;
    logic            bad_q;

    logic [BCD_W-1:0] d;
    logic             bout;
    logic             bad;

    bcd_digit_sub u_digit (
        .a_d  (a_q[BCD_W-1:0]),
        .b_d  (b_q[BCD_W-1:0]),
        .bin  (bin_q),
        .d    (d),
        .bout (bout),
        .bad  (bad)
    );

    // New digits enter at the top so digit 0 ends up at the bottom after DIGITS shifts.
    always_comb begin
        acc_next = acc_q >> BCD_W;
        acc_next[W-1 -: BCD_W] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            bin_q   <= 1'b0;
            bad_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        bin_q   <= 1'b0;
                        bad_q   <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> BCD_W;
                    b_q   <= b_q >> BCD_W;
                    acc_q <= acc_next;
                    bin_q <= bout;
                    bad_q <= bad_q | bad;
                    if (idx_q == LastIdx) begin
                        diff    <= acc_next;
                        borrow  <= bout;
                        invalid <= bad_q | bad;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor: stimulus pushes expectations, a monitor checks done pulses.
module tb_bcd_serial_subtractor;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         inv;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         invalid;

    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: decimal arithmetic for valid operands; raw digit rule when any digit exceeds 9.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        exp_t e;
        int av, bv, r, t, br, pw;
        logic [3:0] nib;
        e.diff = '0;
        e.inv  = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) e.inv = 1'b1;
        if (!e.inv) begin
            av = 0; bv = 0; pw = 1;
            for (int i = 0; i < DIGITS; i++) begin
                av += int'(ma[4*i +: 4]) * pw;
                bv += int'(mb[4*i +: 4]) * pw;
                pw *= 10;
            end
            r = av - bv;
            e.borrow = (r < 0);
            if (r < 0) r += pw;
            for (int i = 0; i < DIGITS; i++) begin
                nib = 4'(r % 10);
                e.diff[4*i +: 4] = nib;
                r = r / 10;
            end
        end else begin
            br = 0;
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(ma[4*i +: 4]) - int'(mb[4*i +: 4]) - br;
                if (t < 0) begin t += 10; br = 1; end
                else br = 0;
                nib = 4'(t % 16);
                e.diff[4*i +: 4] = nib;
            end
            e.borrow = br[0];
        end
        e.cyc = 0;
        return e;
    endfunction

    task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb);
        exp_t e;
        e     = model(ea, eb);
        e.cyc = cyc + DIGITS;
        sb.push_back(e);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob);
        start = 1'b1; a = oa; b = ob;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(oa, ob);
        a = W'($urandom); b = W'($urandom);
        repeat (DIGITS + 1) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // Monitor: every done pulse must match the head of the scoreboard, on the predicted cycle.
    initial begin
        int busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: done pulse at cycle %0d, none pending", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("diff", 32'(diff), 32'(e.diff));
                    chk("borrow", 32'(borrow), 32'(e.borrow));
                    chk("invalid", 32'(invalid), 32'(e.inv));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_with_done", 32'(busy), 32'd0);
                    chk("busy_run_len", 32'(busy_run), 32'(DIGITS));
                end
            end
            busy_run = busy ? busy_run + 1 : 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        cyc = 0; n_checks = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h4321, 16'h1234);
        do_op(16'h0000, 16'h0001);
        do_op(16'h0100, 16'h0099);
        do_op(16'h9999, 16'h9999);
        do_op(16'h00A0, 16'h0000);
        do_op(16'h0005, 16'h0003);

        // Second start two cycles into RUN must be ignored.
        start = 1'b1; a = 16'h4321; b = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(16'h4321, 16'h1234);
        a = 16'h1111; b = 16'h2222;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (DIGITS - 1) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of RUN: outputs clear at once, no done.
        start = 1'b1; a = 16'h7777; b = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_borrow", 32'(borrow), 32'd0);
        chk("midrst_invalid", 32'(invalid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(16'h0500, 16'h0250);

        // start held high: re-accepted every DIGITS+2 cycles.
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ra = rand_bcd(); rb = rand_bcd();
            a = ra; b = rb;
            @(posedge clk); #1;
            push_exp(ra, rb);
            a = W'($urandom); b = W'($urandom);
            if (k < 2) begin
                repeat (DIGITS + 1) @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        repeat (DIGITS + 1) @(posedge clk);
        #1;

        for (int k = 0; k < 20; k++) do_op(rand_bcd(), rand_bcd());

        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
